// File: rtl/alu_nibble_seq.sv
// Nibble-serial ALU sequencer: runs a W-bit add/sub/or/and as NIBBLES passes
// through an external 4-bit ALU, LSB nibble first, behind valid/ready handshakes.
module alu_nibble_seq #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         CmdValid,
    output logic         CmdReady,
    input  logic [2:0]   CmdOp,
    input  logic [W-1:0] CmdX,
    input  logic [W-1:0] CmdY,
    input  logic         CmdCin,
    output logic [3:0]   AluA,
    output logic [3:0]   AluB,
    output logic         AluCin,
    output logic [2:0]   AluCtrl,
    input  logic [3:0]   AluOutput,
    input  logic         AluCout,
    output logic         RspValid,
    input  logic         RspReady,
    output logic [W-1:0] RspResult,
    output logic         RspCout,
    output logic         RspErr
);

    localparam int KW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e          state_q;
    logic [KW-1:0]   k_q;
    logic [2:0]      op_q;
    logic [W-1:0]    x_q;
    logic [W-1:0]    y_q;
    logic [W-1:0]    result_q;
    logic            carry_q;
    logic            err_q;
    logic            cmd_ready_q;
    logic            rsp_valid_q;
    logic [3:0]      alu_a_q;
    logic [3:0]      alu_b_q;
    logic            alu_cin_q;
    logic [2:0]      alu_ctrl_q;

    logic            arith_s;
    logic            last_s;
    logic [3:0]      next_a_d;
    logic [3:0]      next_b_d;

    function automatic logic [3:0] nib_sel(input logic [W-1:0] v, input logic [3:0] idx);
        logic [W-1:0] sh;
        sh = v >> {idx, 2'b00};
        return sh[3:0];
    endfunction

    // Operand nibbles for the following pass and end-of-command detection.
    always_comb begin
        arith_s  = ~op_q[1];
        last_s   = (k_q == KW'(NIBBLES - 1));
        next_a_d = nib_sel(x_q, {1'b0, k_q} + 4'd1);
        next_b_d = nib_sel(y_q, {1'b0, k_q} + 4'd1);
    end

    // Sequencer FSM; every output is a register loaded on the edge that enters its cycle.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            op_q        <= 3'b000;
            x_q         <= '0;
            y_q         <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            alu_a_q     <= 4'h0;
            alu_b_q     <= 4'h0;
            alu_cin_q   <= 1'b0;
            alu_ctrl_q  <= 3'b000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (CmdValid && cmd_ready_q) begin
                        op_q        <= CmdOp;
                        x_q         <= CmdX;
                        y_q         <= CmdY;
                        k_q         <= '0;
                        result_q    <= '0;
                        carry_q     <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        if (!CmdOp[2]) begin
                            state_q    <= EXEC;
                            err_q      <= 1'b0;
                            alu_a_q    <= CmdX[3:0];
                            alu_b_q    <= CmdY[3:0];
                            alu_ctrl_q <= CmdOp;
                            alu_cin_q  <= CmdCin & ~CmdOp[1];
                        end else begin
                            state_q <= RESP;
                            err_q   <= 1'b1;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                EXEC: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (k_q == KW'(i)) begin
                            result_q[4*i +: 4] <= AluOutput;
                        end
                    end
                    // Logical ops never chain a carry, so both the ALU input and RspCout stay 0.
                    carry_q <= AluCout & arith_s;
                    if (last_s) begin
                        state_q    <= RESP;
                        alu_a_q    <= 4'h0;
                        alu_b_q    <= 4'h0;
                        alu_cin_q  <= 1'b0;
                        alu_ctrl_q <= 3'b000;
                    end else begin
                        k_q       <= k_q + KW'(1);
                        alu_a_q   <= next_a_d;
                        alu_b_q   <= next_b_d;
                        alu_cin_q <= AluCout & arith_s;
                    end
                end
                RESP: begin
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                    end else if (RspReady) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    alu_a_q     <= 4'h0;
                    alu_b_q     <= 4'h0;
                    alu_cin_q   <= 1'b0;
                    alu_ctrl_q  <= 3'b000;
                end
            endcase
        end
    end

    assign CmdReady  = cmd_ready_q;
    assign AluA      = alu_a_q;
    assign AluB      = alu_b_q;
    assign AluCin    = alu_cin_q;
    assign AluCtrl   = alu_ctrl_q;
    assign RspValid  = rsp_valid_q;
    assign RspResult = result_q;
    assign RspCout   = carry_q;
    assign RspErr    = err_q;

    alu_nibble_seq_chk #(.W(W)) u_chk (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .exec_i     (state_q == EXEC),
        .cmd_ready_i(cmd_ready_q),
        .rsp_valid_i(rsp_valid_q),
        .rsp_ready_i(RspReady),
        .rsp_result_i(result_q),
        .rsp_cout_i (carry_q),
        .rsp_err_i  (err_q),
        .alu_a_i    (alu_a_q),
        .alu_b_i    (alu_b_q),
        .alu_cin_i  (alu_cin_q),
        .alu_ctrl_i (alu_ctrl_q)
    );

endmodule

// Protocol properties of the sequencer, kept out of the datapath module.
module alu_nibble_seq_chk #(
    parameter int W = 16
) (
    input logic         Clk,
    input logic         Rst_n,
    input logic         exec_i,
    input logic         cmd_ready_i,
    input logic         rsp_valid_i,
    input logic         rsp_ready_i,
    input logic [W-1:0] rsp_result_i,
    input logic         rsp_cout_i,
    input logic         rsp_err_i,
    input logic [3:0]   alu_a_i,
    input logic [3:0]   alu_b_i,
    input logic         alu_cin_i,
    input logic [2:0]   alu_ctrl_i
);

    a_no_overlap: assert property (@(posedge Clk) disable iff (!Rst_n)
        !(cmd_ready_i && rsp_valid_i));

    a_rsp_hold: assert property (@(posedge Clk) disable iff (!Rst_n)
        (rsp_valid_i && !rsp_ready_i) |=>
            (rsp_valid_i && $stable(rsp_result_i) && $stable(rsp_cout_i) && $stable(rsp_err_i)));

    a_alu_idle: assert property (@(posedge Clk) disable iff (!Rst_n)
        !exec_i |-> (alu_a_i == 4'h0 && alu_b_i == 4'h0 && !alu_cin_i && alu_ctrl_i == 3'b000));

    a_ready_not_exec: assert property (@(posedge Clk) disable iff (!Rst_n)
        cmd_ready_i |-> !exec_i);

endmodule
